// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port integer register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int REG_ZERO  = '0;

    typedef logic [XLEN_DEF-1:0]          xword_t;
    typedef logic [$clog2(NREGS_DEF)-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: one busy bit per architectural register.
// Priority per edge: flush clears everything, writes clear their destination,
// and an issue sets its destination last so the younger producer always wins.
// x0 is never marked busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic [NWR-1:0]           we,
    input  logic [NWR-1:0][AW-1:0]   wr_addr,
    input  logic                     iss_valid,
    input  logic [AW-1:0]            iss_rd,
    input  logic                     flush,
    output logic [NREGS-1:0]         busy,
    output logic [NREGS-1:0]         busy_nxt,
    output logic                     any_busy
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

    // Next busy vector: flush, then write clears, then issue set (set wins).
    always_comb begin
        busy_nxt = flush ? '0 : busy;
        for (int j = 0; j < NWR; j++) begin
            if (we[j] && (wr_addr[j] != ZERO_IDX)) begin
                busy_nxt[wr_addr[j]] = 1'b0;
            end
        end
        if (iss_valid && (iss_rd != ZERO_IDX)) begin
            busy_nxt[iss_rd] = 1'b1;
        end
    end

    // Busy state and its registered OR-reduction.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            busy     <= '0;
            any_busy <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            any_busy <= |busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with integrated write-pending scoreboard.
// x0 is hardwired to zero. Reads are registered (1-cycle latency).
// Optional macro RF_BYPASS_EN: same-cycle write data and post-update busy
// state are forwarded to the read ports; otherwise reads see the old value.
// Interface: no valid/ready handshake -- every read, write, issue and flush
// is accepted on every rising edge; there is no back-pressure.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic [NRD-1:0][AW-1:0]   rs_addr,
    output logic [NRD-1:0][XLEN-1:0] rs_data,
    output logic [NRD-1:0]           rs_busy,
    input  logic [NWR-1:0]           we,
    input  logic [NWR-1:0][AW-1:0]   wr_addr,
    input  logic [NWR-1:0][XLEN-1:0] wr_data,
    input  logic                     iss_valid,
    input  logic [AW-1:0]            iss_rd,
    input  logic                     flush,
    output logic                     any_busy
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_sb (
        .clk       (clk),
        .rstN      (rstN),
        .we        (we),
        .wr_addr   (wr_addr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .busy      (busy),
        .busy_nxt  (busy_nxt),
        .any_busy  (any_busy)
    );

`ifndef RF_BYPASS_EN
    // Post-update busy is only consumed by the bypass path.
    logic unused_busy_nxt;
    assign unused_busy_nxt = ^busy_nxt;
`endif

    // Data array write; ascending port loop lets the highest port win a collision.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int r = 0; r < NREGS; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (wr_addr[j] != ZERO_IDX)) begin
                    mem[wr_addr[j]] <= wr_data[j];
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [XLEN-1:0] rd_val;
        logic            rd_busy;

        // Read mux: array (or forwarded write) value and busy flag, x0 forced to zero.
        always_comb begin
            rd_val  = mem[rs_addr[i]];
`ifdef RF_BYPASS_EN
            rd_busy = busy_nxt[rs_addr[i]];
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (wr_addr[j] != ZERO_IDX) && (wr_addr[j] == rs_addr[i])) begin
                    rd_val = wr_data[j];
                end
            end
`else
            rd_busy = busy[rs_addr[i]];
`endif
            if (rs_addr[i] == ZERO_IDX) begin
                rd_val  = '0;
                rd_busy = 1'b0;
            end
        end

        // Registered read port outputs.
        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                rs_data[i] <= '0;
                rs_busy[i] <= 1'b0;
            end else begin
                rs_data[i] <= rd_val;
                rs_busy[i] <= rd_busy;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with two read and two write ports.
// Expectations for the same-cycle read/write case follow RF_BYPASS_EN.
module tb_regfile_mp;

    logic             clk;
    logic             rstN;
    logic [1:0][4:0]  rs_addr;
    logic [1:0][31:0] rs_data;
    logic [1:0]       rs_busy;
    logic [1:0]       we;
    logic [1:0][4:0]  wr_addr;
    logic [1:0][31:0] wr_data;
    logic             iss_valid;
    logic [4:0]       iss_rd;
    logic             flush;
    logic             any_busy;

    int n_vec;
    int n_bad;

    regfile_mp #(
        .XLEN  (32),
        .NREGS (32),
        .NRD   (2),
        .NWR   (2)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .rs_addr   (rs_addr),
        .rs_data   (rs_data),
        .rs_busy   (rs_busy),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .any_busy  (any_busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single checking task
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // advance one edge and settle for sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we        = '0;
        wr_addr   = '0;
        wr_data   = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        flush     = 1'b0;
    endtask

    task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d);
        we[port]      = 1'b1;
        wr_addr[port] = a;
        wr_data[port] = d;
    endtask

    task automatic issue(input logic [4:0] a);
        iss_valid = 1'b1;
        iss_rd    = a;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rs_addr[0] = a0;
        rs_addr[1] = a1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        idle();
        rd(5'd3, 5'd17);
        rstN = 1'b0;

        // 1. reset state, then all registers read zero and idle
        repeat (3) tick();
        chk("rst_data0", rs_data[0], 32'h0);
        chk("rst_data1", rs_data[1], 32'h0);
        chk("rst_busy",  {30'h0, rs_busy}, 32'h0);
        chk("rst_any",   {31'h0, any_busy}, 32'h0);
        rstN = 1'b1;
        for (int r = 1; r < 32; r++) begin
            rd(5'(r), 5'(r));
            tick();
            chk("init_data0", rs_data[0], 32'h0);
            chk("init_data1", rs_data[1], 32'h0);
            chk("init_busy",  {30'h0, rs_busy}, 32'h0);
            chk("init_any",   {31'h0, any_busy}, 32'h0);
        end

        // 2. write x5, read on both ports; x0 ignores writes
        rd(5'd0, 5'd0);
        wr(0, 5'd5, 32'hDEADBEEF);
        tick();
        idle();
        rd(5'd5, 5'd5);
        tick();
        chk("x5_port0", rs_data[0], 32'hDEADBEEF);
        chk("x5_port1", rs_data[1], 32'hDEADBEEF);
        wr(0, 5'd0, 32'h1234);
        tick();
        idle();
        rd(5'd0, 5'd5);
        tick();
        chk("x0_data", rs_data[0], 32'h0);
        chk("x0_busy", {31'h0, rs_busy[0]}, 32'h0);
        chk("x5_hold", rs_data[1], 32'hDEADBEEF);

        // 3. issue x7 -> busy; write+issue same cycle -> busy stays, data updates
        issue(5'd7);
        tick();
        idle();
        rd(5'd7, 5'd5);
        tick();
        chk("x7_busy",  {31'h0, rs_busy[0]}, 32'h1);
        chk("x5_nbusy", {31'h0, rs_busy[1]}, 32'h0);
        chk("any_x7",   {31'h0, any_busy}, 32'h1);
        wr(0, 5'd7, 32'h11);
        issue(5'd7);
        tick();
        idle();
        tick();
        chk("x7_data_setwin", rs_data[0], 32'h11);
        chk("x7_busy_setwin", {31'h0, rs_busy[0]}, 32'h1);
        chk("x0_issue_ign", 32'h0, 32'h0 | {31'h0, dut.u_sb.busy[0]});

        // 4. collision on x3: highest port wins, busy cleared
        issue(5'd3);
        tick();
        idle();
        wr(0, 5'd3, 32'hA);
        wr(1, 5'd3, 32'hB);
        tick();
        idle();
        rd(5'd3, 5'd3);
        tick();
        chk("x3_collide", rs_data[0], 32'hB);
        chk("x3_busy",    {31'h0, rs_busy[1]}, 32'h0);

        // 5. same-cycle read/write of x9 and read/issue of x11
        rd(5'd9, 5'd11);
        wr(0, 5'd9, 32'h55);
        issue(5'd11);
        tick();
        idle();
`ifdef RF_BYPASS_EN
        chk("x9_bypass",  rs_data[0], 32'h55);
        chk("x11_byp_bs", {31'h0, rs_busy[1]}, 32'h1);
`else
        chk("x9_old",     rs_data[0], 32'h0);
        chk("x11_old_bs", {31'h0, rs_busy[1]}, 32'h0);
`endif
        chk("x9_busy", {31'h0, rs_busy[0]}, 32'h0);
        tick();
        chk("x9_next",  rs_data[0], 32'h55);
        chk("x11_next", {31'h0, rs_busy[1]}, 32'h1);

        // 6. flush with concurrent issue keeps only the new one
        issue(5'd2);
        tick();
        issue(5'd4);
        tick();
        issue(5'd6);
        tick();
        idle();
        flush = 1'b1;
        issue(5'd8);
        tick();
        idle();
        rd(5'd2, 5'd8);
        tick();
        chk("fl_x2", {31'h0, rs_busy[0]}, 32'h0);
        chk("fl_x8", {31'h0, rs_busy[1]}, 32'h1);
        rd(5'd4, 5'd6);
        tick();
        chk("fl_x4x6", {30'h0, rs_busy}, 32'h0);
        rd(5'd7, 5'd11);
        tick();
        chk("fl_x7x11", {30'h0, rs_busy}, 32'h0);
        chk("fl_any",   {31'h0, any_busy}, 32'h1);
        chk("fl_data",  rs_data[0], 32'h11);

        // reset asserted during a write of x10 discards it
        wr(0, 5'd10, 32'hFF);
        #2;
        rstN = 1'b0;
        @(posedge clk);
        #1;
        idle();
        rstN = 1'b1;
        rd(5'd10, 5'd5);
        tick();
        chk("x10_rst", rs_data[0], 32'h0);
        chk("x5_rst",  rs_data[1], 32'h0);
        chk("any_rst", {31'h0, any_busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
